// File: rtl/pix_fifo.sv
// pix_fifo: elastic pixel buffer between the DMA downsizer and the scan-out.
// A DEPTH-entry RAM is followed by a one-entry output register (dout).
// Underruns emit black and are counted. A frame sync pulse flushes all pending
// pixels so every frame starts aligned.
`timescale 1ns/1ps
module pix_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 64,
    parameter int LOW   = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     dout_valid,
    input  logic                     ack,
    input  logic                     sync,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     lowwater,
    output logic                     underflow,
    output logic [15:0]              ufl_cnt
);

    localparam int AW = $clog2(DEPTH);
    // Threshold sized to the level bus; LOW <= DEPTH always fits in AW+1 bits.
    localparam logic [AW:0] LOW_L = LOW[AW:0];

    // Storage RAM; no reset so it maps onto block RAM.
    logic [DW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   ufl_cnt_q, ufl_cnt_d;

    logic          full;
    logic          wr_en;
    logic          load;
    logic          underrun;
    logic [AW:0]   level_w;
    logic [DW-1:0] rd_word;

    // Occupancy and handshake decode from the current pointer state.
    always_comb begin
        level_w   = wr_ptr_q - rd_ptr_q;
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        din_ready = rstn && !full && !sync;
        wr_en     = din_valid && din_ready;
        // Refill the output register when it is empty or being consumed.
        load      = (level_w != '0) && (!dout_valid_q || ack) && !sync;
        // A consumer pull with nothing to give; ignored during a flush.
        underrun  = ack && !dout_valid_q && !sync;
    end

    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    // Upstream writes land in the RAM only; there is no bypass into dout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Next-state for pointers, output register and underrun statistics.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        underflow_d  = underflow_q;
        ufl_cnt_d    = ufl_cnt_q;

        if (sync) begin
            // Flush: drop everything not yet written out, output goes black.
            rd_ptr_d     = wr_ptr_q;
            dout_valid_d = 1'b0;
            dout_d       = '0;
        end else if (load) begin
            rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            dout_d       = rd_word;
            dout_valid_d = 1'b1;
        end else if (ack && dout_valid_q) begin
            // Pixel consumed and nothing to replace it: show black.
            dout_valid_d = 1'b0;
            dout_d       = '0;
        end

        if (underrun) begin
            underflow_d = 1'b1;
            if (ufl_cnt_q != 16'hFFFF) begin
                ufl_cnt_d = ufl_cnt_q + 16'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            ufl_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            underflow_q  <= underflow_d;
            ufl_cnt_q    <= ufl_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign level      = level_w;
    assign lowwater   = (level_w < LOW_L);
    assign underflow  = underflow_q;
    assign ufl_cnt    = ufl_cnt_q;

endmodule

// File: tb/tb_pix_fifo.sv
// Directed bench for pix_fifo: fill, drain, concurrent stream, flush,
// mid-stream reset and underrun-counter saturation.
`timescale 1ns/1ps
module tb_pix_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic        ack;
    logic        sync;
    logic [6:0]  level;
    logic        lowwater;
    logic        underflow;
    logic [15:0] ufl_cnt;

    int errors = 0;
    int checks = 0;

    pix_fifo #(.DW(16), .DEPTH(64), .LOW(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ack        (ack),
        .sync       (sync),
        .level      (level),
        .lowwater   (lowwater),
        .underflow  (underflow),
        .ufl_cnt    (ufl_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case something never settles.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; din_valid = 1'b0; din = '0; ack = 1'b0; sync = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        logic [15:0] q[$];
        logic        fire, take;
        logic [15:0] taken, din_cur;
        logic [31:0] exp_w;
        int          pushed, popped, max_level, cyc, exp_lvl;

        // ---------------- reset state ----------------
        rstn = 1'b0; din_valid = 1'b0; din = '0; ack = 1'b0; sync = 1'b0;
        tick(); tick();
        chk("rst_din_ready", din_ready, 0);
        chk("rst_level", level, 0);
        chk("rst_lowwater", lowwater, 1);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_ufl_cnt", ufl_cnt, 0);
        rstn = 1'b1;
        #1;
        chk("rel_din_ready", din_ready, 1);

        // ---------------- fill ----------------
        // 64 RAM entries plus the output register hold 65 words.
        for (int k = 1; k <= 65; k++) begin
            din_valid = 1'b1; din = 16'(k);
            #1;
            chk("fill_ready", din_ready, 1);
            tick();
            exp_lvl = (k == 1) ? 1 : k - 1;
            chk("fill_level", level, exp_lvl);
            chk("fill_lowwater", lowwater, (exp_lvl < 16) ? 1 : 0);
            if (k == 1) chk("fill_lat1_valid", dout_valid, 0);
            if (k == 2) begin
                chk("fill_lat2_valid", dout_valid, 1);
                chk("fill_lat2_dout", dout, 16'h0001);
            end
        end
        // Full: a further write is refused.
        din = 16'h0099;
        #1;
        chk("full_ready", din_ready, 0);
        tick();
        din_valid = 1'b0;
        chk("full_level", level, 64);
        chk("full_dout", dout, 16'h0001);

        // ---------------- drain ----------------
        for (int i = 0; i < 70; i++) begin
            ack = 1'b1;
            tick();
            chk("drain_dout", dout, (i <= 63) ? i + 2 : 0);
            chk("drain_valid", dout_valid, (i <= 63) ? 1 : 0);
        end
        ack = 1'b0;
        chk("drain_end_dout", dout, 0);
        chk("drain_underflow", underflow, 1);
        chk("drain_ufl_cnt", ufl_cnt, 5);
        chk("drain_level", level, 0);
        chk("drain_lowwater", lowwater, 1);

        // ---------------- concurrent stream ----------------
        do_reset();
        chk("rst2_underflow", underflow, 0);
        chk("rst2_ufl_cnt", ufl_cnt, 0);
        pushed = 0; popped = 0; max_level = 0; cyc = 0;
        while (pushed < 2000 && cyc < 20000) begin
            din_valid = (cyc < 10) || ($urandom_range(0, 3) != 0);
            din       = 16'($urandom);
            ack       = (cyc >= 10) && (cyc % 3 == 0);
            din_cur   = din;
            #1;
            fire  = din_valid && din_ready;
            take  = ack && dout_valid;
            taken = dout;
            tick();
            if (fire) begin
                q.push_back(din_cur);
                pushed++;
            end
            if (take) begin
                exp_w = (q.size() != 0) ? {16'h0, q.pop_front()} : 32'hDEAD_BEEF;
                chk("stream_order", {16'h0, taken}, exp_w);
                popped++;
            end
            if (int'(level) > max_level) max_level = int'(level);
            cyc++;
        end
        din_valid = 1'b0; ack = 1'b0;
        chk("stream_words", pushed, 2000);
        chk("stream_max_level", (max_level <= 64) ? 1 : 0, 1);
        chk("stream_ufl_cnt", ufl_cnt, 0);
        chk("stream_underflow", underflow, 0);

        // ---------------- flush ----------------
        do_reset();
        for (int k = 0; k < 21; k++) begin
            din_valid = 1'b1; din = 16'(16'h0100 + k);
            tick();
        end
        din_valid = 1'b0;
        chk("pre_flush_level", level, 20);
        chk("pre_flush_valid", dout_valid, 1);
        chk("pre_flush_dout", dout, 16'h0100);
        sync = 1'b1; din_valid = 1'b1; din = 16'hDEAD; ack = 1'b1;
        #1;
        chk("flush_ready", din_ready, 0);
        tick();
        sync = 1'b0; din_valid = 1'b0; ack = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_valid", dout_valid, 0);
        chk("flush_dout", dout, 0);
        chk("flush_ufl_cnt", ufl_cnt, 0);
        chk("flush_underflow", underflow, 0);
        din_valid = 1'b1; din = 16'h1234;
        #1;
        chk("post_flush_ready", din_ready, 1);
        tick();
        din_valid = 1'b0;
        chk("post_flush_level", level, 1);
        tick();
        chk("post_flush_dout", dout, 16'h1234);
        chk("post_flush_valid", dout_valid, 1);
        chk("post_flush_level0", level, 0);

        // ---------------- mid-operation reset ----------------
        for (int k = 0; k < 30; k++) begin
            din_valid = 1'b1; din = 16'(16'h0200 + k);
            tick();
        end
        din_valid = 1'b0;
        chk("pre_rst_level", level, 30);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", din_ready, 0);
        tick();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_lowwater", lowwater, 1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_ufl_cnt", ufl_cnt, 0);
        rstn = 1'b1;
        din_valid = 1'b1; din = 16'hABCD;
        tick();
        din_valid = 1'b0;
        tick();
        chk("mid_rst_first", dout, 16'hABCD);
        chk("mid_rst_first_valid", dout_valid, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mid_rst_no_stale", dout_valid, 0);
        chk("mid_rst_level0", level, 0);

        // ---------------- counter saturation ----------------
        do_reset();
        ack = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", ufl_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", ufl_cnt, 16'hFFFF);
        repeat (10) tick();
        chk("sat_hold", ufl_cnt, 16'hFFFF);
        chk("sat_underflow", underflow, 1);
        chk("sat_dout", dout, 0);
        ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
